// File: rtl/vend_pkg.sv
// -----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending machine datapath.
//   - Coin index constants. The index is both the bit position in the one-hot
//     eject vector and the slot in per-denomination arrays.
//   - State encoding for the coin dispenser FSM.
//   - Helpers that pick the next coin to dispense and build its one-hot
//     eject code.
// -----------------------------------------------------------------------------
package vend_pkg;

    localparam logic [1:0] COIN_HALF    = 2'd3;
    localparam logic [1:0] COIN_QUARTER = 2'd2;
    localparam logic [1:0] COIN_DIME    = 2'd1;
    localparam logic [1:0] COIN_NICKEL  = 2'd0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EJECT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } disp_state_e;

    // Highest denomination that still has a nonzero pending count.
    // Returns nickel when every count is zero; callers check for that first.
    function automatic logic [1:0] pick_coin(input logic [3:0] half,
                                             input logic [3:0] quarter,
                                             input logic [3:0] dime,
                                             input logic [3:0] nickel);
        logic [1:0] sel;
        sel = COIN_NICKEL;
        if (nickel != 4'd0)  sel = COIN_NICKEL;
        if (dime != 4'd0)    sel = COIN_DIME;
        if (quarter != 4'd0) sel = COIN_QUARTER;
        if (half != 4'd0)    sel = COIN_HALF;
        return sel;
    endfunction

    function automatic logic [3:0] coin_onehot(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/coin_pulse_timer.sv
// -----------------------------------------------------------------------------
// coin_pulse_timer
// Down-counter that times eject pulses and the gaps between them.
// Loading N makes expire_o high on the N-th cycle after the load, so a state
// that loads on its way in and leaves on expire lasts exactly N cycles.
// Ports:
//   clock_i     in  1  system clock
//   reset_n_i   in  1  asynchronous active-low reset
//   load_i      in  1  load load_val_i (has priority over counting)
//   load_val_i  in  W  cycle count to time
//   expire_o    out 1  high on the last cycle of the timed interval
// -----------------------------------------------------------------------------
module coin_pulse_timer #(
    parameter int W = 3
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = (count_q == W'(1));

endmodule

// File: rtl/coin_dispenser.sv
// -----------------------------------------------------------------------------
// coin_dispenser
// Latches the four coin counts on a rising edge of done_change_maker, then
// ejects the coins one at a time (half dollar first, nickel last) with a
// fixed pulse/gap timing. Owns the coin inventory and reports which
// denominations are still available.
// Optional feature macro: COIN_REFILL_EN adds the refill port group; refills
// are applied only while idle and saturate at the counter maximum.
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   enable                    synchronous clear of the current job and fault
//   done_change_maker         job trigger (rising edge, ignored while busy)
//   half_dollar..nickel [4]   coin counts to dispense
//   refill, refill_sel, refill_amount   (COIN_REFILL_EN only)
//   eject [4]                 one-hot solenoid drive (3=half .. 0=nickel)
//   busy                      job in progress
//   done_dispense             one-cycle pulse at job end
//   fault                     sticky: a requested coin was out of stock
//   is_there_coin [4]         per-denomination inventory nonzero
// -----------------------------------------------------------------------------
module coin_dispenser
    import vend_pkg::*;
#(
    parameter int INV_W        = 6,
    parameter int INIT_COUNT   = 20,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             done_change_maker,
    input  logic [3:0]       half_dollar,
    input  logic [3:0]       quarter,
    input  logic [3:0]       dime,
    input  logic [3:0]       nickel,
`ifdef COIN_REFILL_EN
    input  logic             refill,
    input  logic [1:0]       refill_sel,
    input  logic [INV_W-1:0] refill_amount,
`endif
    output logic [3:0]       eject,
    output logic             busy,
    output logic             done_dispense,
    output logic             fault,
    output logic [3:0]       is_there_coin
);

    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    disp_state_e      state_q, state_d;
    logic [3:0]       cnt_q [4];
    logic [3:0]       cnt_d [4];
    logic [INV_W-1:0] inv_q [4];
    logic [INV_W-1:0] inv_d [4];
    logic             fault_q, fault_d;
    logic             edge_q;
    // entry_q marks the first cycle of an EJECT visit, where the stock check
    // and the inventory/pending decrements happen.
    logic             entry_q, entry_d;
    // Coin being ejected; frozen for the whole pulse because the pending
    // count (and therefore the priority pick) changes on the entry cycle.
    logic [1:0]       cur_q, cur_d;

    logic             rise;
    logic             pending;
    logic             cur_empty;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_expire;

    assign rise      = done_change_maker & ~edge_q;
    assign pending   = (cnt_q[3] != 4'd0) | (cnt_q[2] != 4'd0) |
                       (cnt_q[1] != 4'd0) | (cnt_q[0] != 4'd0);
    assign cur_empty = (inv_q[cur_q] == '0);

`ifdef COIN_REFILL_EN
    logic [INV_W:0] refill_sum;
    assign refill_sum = {1'b0, inv_q[refill_sel]} + {1'b0, refill_amount};
`endif

    coin_pulse_timer #(
        .W(TMR_W)
    ) u_timer (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_val),
        .expire_o  (tmr_expire)
    );

    always_comb begin
        state_d  = state_q;
        fault_d  = fault_q;
        cur_d    = cur_q;
        entry_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = TMR_W'(PULSE_CYCLES);
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            inv_d[i] = inv_q[i];
        end

        if (enable) begin
            state_d = ST_IDLE;
            fault_d = 1'b0;
            for (int i = 0; i < 4; i++) cnt_d[i] = 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        cnt_d[COIN_HALF]    = half_dollar;
                        cnt_d[COIN_QUARTER] = quarter;
                        cnt_d[COIN_DIME]    = dime;
                        cnt_d[COIN_NICKEL]  = nickel;
                        if ((half_dollar | quarter | dime | nickel) != 4'd0) begin
                            state_d  = ST_EJECT;
                            cur_d    = pick_coin(half_dollar, quarter, dime, nickel);
                            entry_d  = 1'b1;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
`ifdef COIN_REFILL_EN
                    if (refill) begin
                        inv_d[refill_sel] = refill_sum[INV_W] ? '1 : refill_sum[INV_W-1:0];
                    end
`endif
                end
                ST_EJECT: begin
                    if (entry_q && cur_empty) begin
                        // Out of stock: abandon the rest of the job.
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                        for (int i = 0; i < 4; i++) cnt_d[i] = 4'd0;
                    end else begin
                        if (entry_q) begin
                            inv_d[cur_q] = inv_q[cur_q] - INV_W'(1);
                            cnt_d[cur_q] = cnt_q[cur_q] - 4'd1;
                        end
                        if (tmr_expire) begin
                            state_d  = ST_GAP;
                            tmr_load = 1'b1;
                            tmr_val  = TMR_W'(GAP_CYCLES);
                        end
                    end
                end
                ST_GAP: begin
                    if (tmr_expire) begin
                        if (pending) begin
                            state_d  = ST_EJECT;
                            cur_d    = pick_coin(cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]);
                            entry_d  = 1'b1;
                            tmr_load = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            fault_q <= 1'b0;
            edge_q  <= 1'b0;
            entry_q <= 1'b0;
            cur_q   <= COIN_NICKEL;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= 4'd0;
                inv_q[i] <= INV_W'(INIT_COUNT);
            end
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
            // Tracks the level even while busy so a held-high level never
            // looks like a new edge once the job ends.
            edge_q  <= done_change_maker;
            entry_q <= entry_d;
            cur_q   <= cur_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
                inv_q[i] <= inv_d[i];
            end
        end
    end

    // The solenoid stays off on an entry cycle that discovers an empty slot.
    assign eject = (state_q == ST_EJECT && !(entry_q && cur_empty)) ? coin_onehot(cur_q) : 4'b0000;
    assign busy          = (state_q != ST_IDLE);
    assign done_dispense = (state_q == ST_DONE);
    assign fault         = fault_q;

    for (genvar gi = 0; gi < 4; gi++) begin : g_avail
        assign is_there_coin[gi] = (inv_q[gi] != '0);
    end

endmodule

// File: tb/tb_coin_dispenser.sv
module tb_coin_dispenser;

    localparam int P       = 4;
    localparam int G       = 4;
    localparam int PER     = P + G;
    localparam int INIT    = 20;
    localparam int INV_MAX = 63;
    localparam int NEVER   = 1 << 30;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b0;
    logic       dcm = 1'b0;
    logic [3:0] c_half = 4'd0, c_quarter = 4'd0, c_dime = 4'd0, c_nickel = 4'd0;
`ifdef COIN_REFILL_EN
    logic       refill = 1'b0;
    logic [1:0] refill_sel = 2'd0;
    logic [5:0] refill_amount = 6'd0;
`endif
    logic [3:0] eject;
    logic       busy;
    logic       done_dispense;
    logic       fault;
    logic [3:0] itc;

    coin_dispenser dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .enable           (enable),
        .done_change_maker(dcm),
        .half_dollar      (c_half),
        .quarter          (c_quarter),
        .dime             (c_dime),
        .nickel           (c_nickel),
`ifdef COIN_REFILL_EN
        .refill           (refill),
        .refill_sel       (refill_sel),
        .refill_amount    (refill_amount),
`endif
        .eject            (eject),
        .busy             (busy),
        .done_dispense    (done_dispense),
        .fault            (fault),
        .is_there_coin    (itc)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        bit         is_done;
        logic [3:0] coin;
        int         t;
        bit         flt;
        logic [3:0] itc;
    } ev_t;

    ev_t sb[$];
    int  compared = 0;
    int  mismatched = 0;
    int  inv[4];
    bit  mdl_fault = 0;
    int  last_done_t = 0;
    bit  skip_width = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] mdl_itc();
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = (inv[i] != 0);
        return r;
    endfunction

    // Reference: coins leave highest denomination first, one every PER cycles
    // starting at t0; an empty slot ends the job one cycle after it is reached.
    // Nothing at or after 'limit' happens (job cut short by enable or reset).
    task automatic model_job(input int ch, input int cq, input int cd, input int cn,
                             input int t0, input int limit);
        int  cnt[4];
        int  k;
        bit  flt;
        bit  stop;
        ev_t e;
        cnt[3] = ch; cnt[2] = cq; cnt[1] = cd; cnt[0] = cn;
        k = 0; flt = 0; stop = 0;
        for (int dd = 3; dd >= 0; dd--) begin
            if (flt || stop) break;
            for (int j = 0; j < cnt[dd]; j++) begin
                int t;
                t = t0 + PER * k;
                if (t >= limit) begin stop = 1; break; end
                if (inv[dd] == 0) begin flt = 1; mdl_fault = 1; break; end
                inv[dd] = inv[dd] - 1;
                e.is_done = 0; e.coin = 4'b0001 << dd; e.t = t; e.flt = 0; e.itc = 4'b0;
                sb.push_back(e);
                k++;
            end
        end
        last_done_t = t0 + PER * k + (flt ? 1 : 0);
        if (!stop && last_done_t < limit) begin
            e.is_done = 1; e.coin = 4'b0; e.t = last_done_t; e.flt = mdl_fault; e.itc = mdl_itc();
            sb.push_back(e);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a coin pulse or
    // a job completion.
    initial begin
        logic [3:0] prev_ej;
        int         width;
        ev_t        e;
        prev_ej = 4'b0;
        width = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                prev_ej = 4'b0;
                width = 0;
            end else begin
                if (eject != 4'b0 && prev_ej == 4'b0) begin
                    width = 1;
                    if (sb.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_coin: got eject=%b at cycle %0d, required no pulse", eject, cyc);
                    end else begin
                        e = sb.pop_front();
                        check("coin_kind", e.is_done, 0);
                        check("coin_id", eject, e.coin);
                        check("coin_time", cyc, e.t);
                    end
                end else if (eject != 4'b0) begin
                    width++;
                    check("eject_stable", eject, prev_ej);
                end else if (prev_ej != 4'b0 && !skip_width) begin
                    check("pulse_width", width, P);
                end
                if (done_dispense) begin
                    $display("tx job_done cycle=%0d fault=%0b is_there_coin=%b", cyc, fault, itc);
                    if (sb.size() == 0) begin
                        compared++; mismatched++;
                        $display("FAIL unexpected_done: got done_dispense at cycle %0d, required none", cyc);
                    end else begin
                        e = sb.pop_front();
                        check("done_kind", e.is_done, 1);
                        check("done_time", cyc, e.t);
                        check("done_fault", fault, e.flt);
                        check("done_itc", itc, e.itc);
                    end
                end
                prev_ej = eject;
            end
        end
    end

    task automatic tick(input int nn);
        repeat (nn) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while (busy && b < 2000) begin
            tick(1);
            b++;
        end
        check("wait_idle_busy", busy, 0);
    endtask

    task automatic pulse_enable();
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        mdl_fault = 0;
        check("enable_clears_fault", fault, 0);
    endtask

    // hold < 0: keep done_change_maker high until well past the job end.
    task automatic run_job(input int ch, input int cq, input int cd, input int cn,
                           input int hold, input bit toggle);
        int h;
        tick(1);
        c_half = 4'(ch); c_quarter = 4'(cq); c_dime = 4'(cd); c_nickel = 4'(cn);
        dcm = 1'b1;
        model_job(ch, cq, cd, cn, cyc + 1, NEVER);
        tick(1);
        c_half = 4'($urandom); c_quarter = 4'($urandom);
        c_dime = 4'($urandom); c_nickel = 4'($urandom);
        if (toggle && last_done_t > cyc + 4) begin
            tick(1); dcm = 1'b0;
            tick(1); dcm = 1'b1;
        end
        h = (hold < 0) ? (last_done_t - cyc + 5) : hold;
        if (h > 0) tick(h);
        dcm = 1'b0;
        wait_idle();
        tick(2);
    endtask

`ifdef COIN_REFILL_EN
    task automatic do_refill(input int sel, input int amt);
        tick(1);
        refill = 1'b1; refill_sel = 2'(sel); refill_amount = 6'(amt);
        inv[sel] = (inv[sel] + amt > INV_MAX) ? INV_MAX : inv[sel] + amt;
        tick(1);
        refill = 1'b0;
    endtask
`endif

    initial begin
        int t0;
        int lim;
        for (int i = 0; i < 4; i++) inv[i] = INIT;

        // Reset state
        tick(2);
        check("rst_eject", eject, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done_dispense, 0);
        check("rst_fault", fault, 0);
        check("rst_itc", itc, 4'b1111);
        reset_n = 1'b1;
        tick(2);

        // Half + dime, then an all-zero job
        run_job(1, 0, 1, 0, 2, 0);
        run_job(0, 0, 0, 0, 2, 0);

        // enable during the second pulse
        tick(1);
        c_half = 4'd1; c_quarter = 4'd2; c_dime = 4'd0; c_nickel = 4'd0;
        dcm = 1'b1;
        t0 = cyc + 1;
        lim = t0 + PER + 2;
        model_job(1, 2, 0, 0, t0, lim);
        tick(1);
        dcm = 1'b0;
        while (cyc < lim) tick(1);
        skip_width = 1;
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        mdl_fault = 0;
        check("abort_eject", eject, 0);
        check("abort_busy", busy, 0);
        check("abort_fault", fault, 0);
        tick(3);
        skip_width = 0;

        // Level held high across the end of the job, with an ignored re-edge
        run_job(0, 1, 0, 1, -1, 1);

        // Drain nickels until the stock runs out
        run_job(0, 0, 0, 15, 3, 1);
        run_job(0, 0, 0, 15, 3, 0);
        check("nickel_gone", itc[0], 0);
        pulse_enable();

`ifdef COIN_REFILL_EN
        // Refill while busy is ignored
        tick(1);
        c_half = 4'd1; c_quarter = 4'd0; c_dime = 4'd0; c_nickel = 4'd0;
        dcm = 1'b1;
        model_job(1, 0, 0, 0, cyc + 1, NEVER);
        tick(3);
        refill = 1'b1; refill_sel = 2'd0; refill_amount = 6'd5;
        tick(1);
        refill = 1'b0;
        dcm = 1'b0;
        wait_idle();
        tick(2);
        check("refill_busy_ignored", itc[0], 0);
        // Saturating refills while idle
        do_refill(1, 63);
        do_refill(1, 1);
        check("refill_dime_sat", itc[1], 1);
        do_refill(0, 3);
        check("refill_nickel", itc[0], 1);
        run_job(0, 0, 0, 4, 2, 0);
        pulse_enable();
`endif

        // Asynchronous reset in the middle of a pulse
        tick(1);
        c_half = 4'd2; c_quarter = 4'd0; c_dime = 4'd0; c_nickel = 4'd0;
        dcm = 1'b1;
        t0 = cyc + 1;
        lim = t0 + 2;
        model_job(2, 0, 0, 0, t0, lim);
        tick(1);
        dcm = 1'b0;
        while (cyc < lim) tick(1);
        skip_width = 1;
        reset_n = 1'b0;
        #1;
        check("async_rst_eject", eject, 0);
        check("async_rst_busy", busy, 0);
        for (int i = 0; i < 4; i++) inv[i] = INIT;
        mdl_fault = 0;
        tick(2);
        reset_n = 1'b1;
        check("rst_restore_itc", itc, 4'b1111);
        check("rst_restore_fault", fault, 0);
        tick(2);
        skip_width = 0;

        // Randomised jobs against the reference model
        for (int j = 0; j < 30; j++) begin
            int ch, cq, cd, cn;
            if ($urandom_range(0, 4) == 0) begin
                ch = 0; cq = 0; cd = 0; cn = 0;
            end else begin
                ch = $urandom_range(0, 3); cq = $urandom_range(0, 3);
                cd = $urandom_range(0, 3); cn = $urandom_range(0, 3);
            end
            run_job(ch, cq, cd, cn, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) pulse_enable();
        end

        tick(5);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
